// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Single-beat AXI-style read reorder buffer. Each upstream AR is given the
//   next slot of a 16-entry circular buffer, and the slot index is sent
//   downstream as the transaction ID. Downstream R beats may come back in any
//   order. They are parked in their slot and released upstream strictly in
//   AR-acceptance order, tagged with the original upstream ID.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   s_arid_i/s_arvalid_i/s_arready_o  upstream AR channel
//   m_arid_o/m_arvalid_o/m_arready_i  downstream AR channel (id = slot index)
//   s_rdata_o/s_rid_o/s_rvalid_o/s_rready_i  upstream R channel (in order)
//   m_rdata_i/m_rid_i/m_rvalid_i/m_rready_o  downstream R channel (any order)
module reorder_buffer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            s_arid_i,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   output logic [3:0]            m_arid_o,
   output logic                  m_arvalid_o,
   input  logic                  m_arready_i,
   output logic [DATA_WIDTH-1:0] s_rdata_o,
   output logic [3:0]            s_rid_o,
   output logic                  s_rvalid_o,
   input  logic                  s_rready_i,
   input  logic [DATA_WIDTH-1:0] m_rdata_i,
   input  logic [3:0]            m_rid_i,
   input  logic                  m_rvalid_i,
   output logic                  m_rready_o
);

   localparam int DEPTH = 16;

   logic [DEPTH-1:0][3:0]            orig_id_q;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
   logic [DEPTH-1:0]                 alloc_q;
   logic [DEPTH-1:0]                 done_q;
   logic [3:0]                       wr_ptr_q;
   logic [3:0]                       rd_ptr_q;
   logic [4:0]                       count;
   logic                             m_rready_q;

   logic full, ar_hs, r_fill, r_pop;

   assign full = (count == 5'd16);

   // AR is a pure pass-through gated only by occupancy.
   assign m_arvalid_o = s_arvalid_i & ~full;
   assign s_arready_o = m_arready_i & ~full;
   assign m_arid_o    = wr_ptr_q;
   assign ar_hs       = s_arvalid_i & s_arready_o;

   // Downstream R is always accepted once out of reset; beats for free or
   // already-filled slots are swallowed so a misbehaving subordinate cannot
   // corrupt a live entry.
   assign m_rready_o  = m_rready_q;
   assign r_fill      = m_rvalid_i & m_rready_q & alloc_q[m_rid_i] & ~done_q[m_rid_i];

   // Head slot drives the upstream R channel directly.
   assign s_rvalid_o  = alloc_q[rd_ptr_q] & done_q[rd_ptr_q];
   assign s_rid_o     = orig_id_q[rd_ptr_q];
   assign s_rdata_o   = data_q[rd_ptr_q];
   assign r_pop       = s_rvalid_o & s_rready_i;

   // Allocation, fill and pop always target distinct slots: allocation needs
   // a free slot, fill needs an allocated-not-done slot, pop needs a done slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         orig_id_q  <= '0;
         data_q     <= '0;
         alloc_q    <= '0;
         done_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count      <= '0;
         m_rready_q <= 1'b0;
      end else begin
         m_rready_q <= 1'b1;
         if (ar_hs) begin
            orig_id_q[wr_ptr_q] <= s_arid_i;
            alloc_q[wr_ptr_q]   <= 1'b1;
            done_q[wr_ptr_q]    <= 1'b0;
            wr_ptr_q            <= wr_ptr_q + 4'd1;
         end
         if (r_fill) begin
            data_q[m_rid_i] <= m_rdata_i;
            done_q[m_rid_i] <= 1'b1;
         end
         if (r_pop) begin
            alloc_q[rd_ptr_q] <= 1'b0;
            done_q[rd_ptr_q]  <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + 4'd1;
         end
         case ({ar_hs, r_pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] s_arid_i;
   logic       s_arvalid_i;
   logic       s_arready_o;
   logic [3:0] m_arid_o;
   logic       m_arvalid_o;
   logic       m_arready_i;
   logic [7:0] s_rdata_o;
   logic [3:0] s_rid_o;
   logic       s_rvalid_o;
   logic       s_rready_i;
   logic [7:0] m_rdata_i;
   logic [3:0] m_rid_i;
   logic       m_rvalid_i;
   logic       m_rready_o;

   reorder_buffer #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
      .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
      .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
      .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_id_q[$];
   logic [3:0] exp_slot_q[$];
   logic [7:0] slot_data[16];
   logic [3:0] tb_wr = 4'd0;
   logic [3:0] mon_id, mon_slot;

   // Scoreboard: every upstream R handshake must match the oldest accepted AR.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && s_rvalid_o === 1'b1 && s_rready_i === 1'b1) begin
         checks++;
         if (exp_id_q.size() == 0) begin
            errors++;
            $display("FAIL r_order: unexpected beat rid=%0d data=%h, required no beat", s_rid_o, s_rdata_o);
         end else begin
            mon_id   = exp_id_q.pop_front();
            mon_slot = exp_slot_q.pop_front();
            if (s_rid_o !== mon_id || s_rdata_o !== slot_data[mon_slot]) begin
               errors++;
               $display("FAIL r_order: got rid=%0d data=%h, required rid=%0d data=%h",
                        s_rid_o, s_rdata_o, mon_id, slot_data[mon_slot]);
            end
         end
      end
   end

   task automatic send_ar(input logic [3:0] id);
      s_arvalid_i = 1'b1;
      s_arid_i    = id;
      @(negedge clk);
      checks++;
      if (s_arready_o !== 1'b1 || m_arvalid_o !== 1'b1 || m_arid_o !== tb_wr) begin
         errors++;
         $display("FAIL ar_issue: arready=%b arvalid=%b arid=%0d, required 1 1 %0d",
                  s_arready_o, m_arvalid_o, m_arid_o, tb_wr);
      end
      exp_id_q.push_back(id);
      exp_slot_q.push_back(tb_wr);
      tb_wr = tb_wr + 4'd1;
      @(posedge clk); #1;
      s_arvalid_i = 1'b0;
   endtask

   task automatic send_r(input logic [3:0] slot, input logic [7:0] data);
      m_rvalid_i      = 1'b1;
      m_rid_i         = slot;
      m_rdata_i       = data;
      slot_data[slot] = data;
      @(posedge clk); #1;
      m_rvalid_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_id_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_id_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_id_q.size());
         exp_id_q.delete();
         exp_slot_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_arid_i = '0; s_arvalid_i = 1'b0; m_arready_i = 1'b0;
      s_rready_i = 1'b0; m_rdata_i = '0; m_rid_i = '0; m_rvalid_i = 1'b0;
      #2;
      checks++;
      if (s_rvalid_o !== 1'b0 || s_rid_o !== 4'd0 || s_rdata_o !== 8'd0 || m_rready_o !== 1'b0 || m_arid_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_vals: rvalid=%b rid=%0d rdata=%h mrready=%b arid=%0d, required 0 0 00 0 0",
                  s_rvalid_o, s_rid_o, s_rdata_o, m_rready_o, m_arid_o);
      end
      s_arvalid_i = 1'b1; m_arready_i = 1'b1; #1;
      checks++;
      if (m_arvalid_o !== 1'b1 || s_arready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_passthru: arvalid=%b arready=%b, required 1 1", m_arvalid_o, s_arready_o);
      end
      s_arvalid_i = 1'b0; m_arready_i = 1'b0; #1;
      checks++;
      if (m_arvalid_o !== 1'b0 || s_arready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_passthru0: arvalid=%b arready=%b, required 0 0", m_arvalid_o, s_arready_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1; #1;
      checks++;
      if (m_rready_o !== 1'b0) begin
         errors++;
         $display("FAIL rready_release: got %b, required 0", m_rready_o);
      end
      @(posedge clk); #1;
      checks++;
      if (m_rready_o !== 1'b1) begin
         errors++;
         $display("FAIL rready_first_clk: got %b, required 1", m_rready_o);
      end
      m_arready_i = 1'b1;
   endtask

   // Fill all 16 slots, return them shuffled with the head held back, then
   // pop once at full and confirm AR reopens on the wrapped slot 0.
   task automatic test_fill_wrap();
      int   perm[16];
      int   j, t;
      logic seen0 = 1'b0;
      s_rready_i = 1'b0;
      for (int i = 0; i < 16; i++) send_ar(4'(i));
      s_arvalid_i = 1'b1;
      @(negedge clk);
      checks++;
      if (s_arready_o !== 1'b0 || m_arvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL full_block: arready=%b arvalid=%b, required 0 0", s_arready_o, m_arvalid_o);
      end
      @(posedge clk); #1;
      s_arvalid_i = 1'b0;
      for (int i = 0; i < 16; i++) perm[i] = i;
      for (int i = 15; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int k = 0; k < 16; k++) begin
         send_r(4'(perm[k]), 8'(perm[k]));
         if (perm[k] == 0) seen0 = 1'b1;
         @(negedge clk);
         checks++;
         if (s_rvalid_o !== seen0) begin
            errors++;
            $display("FAIL head_wait k=%0d: rvalid=%b, required %b", k, s_rvalid_o, seen0);
         end
      end
      @(posedge clk); #1;
      s_rready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (s_arready_o !== 1'b0) begin
         errors++;
         $display("FAIL full_before_pop: arready=%b, required 0", s_arready_o);
      end
      @(posedge clk); #1;
      s_rready_i = 1'b0;
      @(negedge clk);
      checks++;
      if (s_arready_o !== 1'b1 || m_arid_o !== 4'd0) begin
         errors++;
         $display("FAIL full_resume: arready=%b arid=%0d, required 1 0", s_arready_o, m_arid_o);
      end
      @(posedge clk); #1;
      s_rready_i = 1'b1;
      wait_drain("fill");
   endtask

   task automatic test_dup_ids();
      logic [3:0] base;
      base = tb_wr;
      s_rready_i = 1'b1;
      send_ar(4'd5); send_ar(4'd5); send_ar(4'd9);
      send_r(base + 4'd2, 8'hA2);
      send_r(base,        8'hA0);
      send_r(base + 4'd1, 8'hA1);
      wait_drain("dup");
   endtask

   task automatic test_hold();
      logic [3:0] slot;
      s_rready_i = 1'b0;
      slot = tb_wr;
      send_ar(4'd3);
      send_r(slot, 8'h33);
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (s_rvalid_o !== 1'b1 || s_rid_o !== 4'd3 || s_rdata_o !== 8'h33) begin
            errors++;
            $display("FAIL hold: rvalid=%b rid=%0d data=%h, required 1 3 33", s_rvalid_o, s_rid_o, s_rdata_o);
         end
         @(posedge clk); #1;
      end
      s_rready_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (s_rvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL hold_popped: rvalid=%b, required 0", s_rvalid_o);
      end
      wait_drain("hold");
   endtask

   task automatic test_no_alloc_spurious();
      logic [3:0] slot;
      m_arready_i = 1'b0;
      s_arvalid_i = 1'b1; s_arid_i = 4'hE;
      @(negedge clk);
      checks++;
      if (s_arready_o !== 1'b0 || m_arvalid_o !== 1'b1 || m_arid_o !== tb_wr) begin
         errors++;
         $display("FAIL no_alloc: arready=%b arvalid=%b arid=%0d, required 0 1 %0d",
                  s_arready_o, m_arvalid_o, m_arid_o, tb_wr);
      end
      @(posedge clk); #1;
      s_arvalid_i = 1'b0; m_arready_i = 1'b1;
      m_rvalid_i = 1'b1; m_rid_i = 4'd7; m_rdata_i = 8'h77;
      @(negedge clk);
      checks++;
      if (m_rready_o !== 1'b1) begin
         errors++;
         $display("FAIL spurious_accept: rready=%b, required 1", m_rready_o);
      end
      @(posedge clk); #1;
      m_rvalid_i = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (s_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious_out: rvalid=%b, required 0", s_rvalid_o);
         end
         @(posedge clk); #1;
      end
      slot = tb_wr;
      send_ar(4'hC);
      send_r(slot, 8'h5C);
      wait_drain("spurious");
   endtask

   // AR allocation, downstream fill and upstream pop all in the same cycles.
   task automatic test_back_to_back();
      logic [3:0] prev = 4'd0;
      s_rready_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin
            s_arvalid_i = 1'b1;
            s_arid_i    = 4'(i) ^ 4'hA;
         end
         if (i > 0) begin
            m_rvalid_i      = 1'b1;
            m_rid_i         = prev;
            m_rdata_i       = 8'h40 + 8'(i);
            slot_data[prev] = 8'h40 + 8'(i);
         end
         @(negedge clk);
         if (i < 8) begin
            checks++;
            if (s_arready_o !== 1'b1 || m_arid_o !== tb_wr) begin
               errors++;
               $display("FAIL b2b_ar i=%0d: arready=%b arid=%0d, required 1 %0d", i, s_arready_o, m_arid_o, tb_wr);
            end
            exp_id_q.push_back(4'(i) ^ 4'hA);
            exp_slot_q.push_back(tb_wr);
            prev  = tb_wr;
            tb_wr = tb_wr + 4'd1;
         end
         @(posedge clk); #1;
         s_arvalid_i = 1'b0;
         m_rvalid_i  = 1'b0;
      end
      wait_drain("b2b");
   endtask

   task automatic test_reset_mid();
      logic [3:0] base;
      s_rready_i = 1'b0;
      base = tb_wr;
      for (int i = 0; i < 6; i++) send_ar(4'(i + 1));
      send_r(base, 8'h99);
      @(negedge clk);
      checks++;
      if (s_rvalid_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: rvalid=%b, required 1", s_rvalid_o);
      end
      #2; rst_n = 1'b0; #1;
      checks++;
      if (s_rvalid_o !== 1'b0 || dut.count !== 5'd0 || m_rready_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: rvalid=%b count=%0d rready=%b, required 0 0 0", s_rvalid_o, dut.count, m_rready_o);
      end
      exp_id_q.delete();
      exp_slot_q.delete();
      tb_wr = 4'd0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send_ar(4'd2);
      s_rready_i = 1'b1;
      send_r(4'd0, 8'h12);
      wait_drain("mid");
   endtask

   initial begin
      test_reset();
      test_fill_wrap();
      test_dup_ids();
      test_hold();
      test_no_alloc_spurious();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Single-beat AXI-style read reorder buffer between an upstream master (slave-side ports, s_*) and a downstream subordinate (master-side ports, m_*).
- Each accepted AR is allocated the next slot of a 16-entry circular buffer; the slot index is issued downstream as the transaction ID.
- Downstream R responses may return in any order. Upstream sees R responses strictly in AR-acceptance order, carrying the original upstream ID.

Parameters:
- DATA_WIDTH, 8, width of read data path in bits.
- DEPTH fixed at 16 (4-bit ID space); not a parameter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_arid_i  in  4  upstream AR ID
- s_arvalid_i  in  1  upstream AR valid
- s_arready_o  out  1  upstream AR ready
- m_arid_o  out  4  downstream AR ID (= allocated slot index)
- m_arvalid_o  out  1  downstream AR valid
- m_arready_i  in  1  downstream AR ready
- s_rdata_o  out  DATA_WIDTH  upstream R data
- s_rid_o  out  4  upstream R ID (original s_arid_i)
- s_rvalid_o  out  1  upstream R valid
- s_rready_i  in  1  upstream R ready
- m_rdata_i  in  DATA_WIDTH  downstream R data
- m_rid_i  in  4  downstream R ID (slot index)
- m_rvalid_i  in  1  downstream R valid
- m_rready_o  out  1  downstream R ready

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Reset clears all state at any time, including mid-transaction; outstanding transactions are discarded.
- State:
  - per slot: orig_id[3:0], data[DATA_WIDTH-1:0], alloc bit, done bit
  - wr_ptr[3:0] (tail), rd_ptr[3:0] (head); both wrap 15->0
  - count[4:0], range 0..16
- full = (count == 16).
- AR path, combinational pass-through, zero latency:
  - m_arvalid_o = s_arvalid_i & ~full
  - s_arready_o = m_arready_i & ~full
  - m_arid_o = wr_ptr
- AR handshake = s_arvalid_i & s_arready_o. On handshake:
  - orig_id[wr_ptr] <= s_arid_i
  - alloc[wr_ptr] <= 1, done[wr_ptr] <= 0
  - wr_ptr++
- Upstream IDs are not required to be unique; duplicates occupy separate slots.
- R input:
  - m_rready_o is a register: 0 in reset, 1 from the first clock after reset release.
  - On m_rvalid_i & m_rready_o: if alloc[m_rid_i] & ~done[m_rid_i], then data[m_rid_i] <= m_rdata_i and done[m_rid_i] <= 1.
  - Otherwise (unallocated or already-done slot) the beat is accepted and dropped.
- R output, combinational from head slot:
  - s_rvalid_o = alloc[rd_ptr] & done[rd_ptr]
  - s_rid_o = orig_id[rd_ptr]
  - s_rdata_o = data[rd_ptr]
- On s_rvalid_o & s_rready_i: alloc[rd_ptr] <= 0, done[rd_ptr] <= 0, rd_ptr++.
- Latency: an R beat written at edge N (head slot) gives s_rvalid_o high after edge N. Minimum AR-to-upstream-R is response arrival plus 1 cycle.
- s_rvalid_o, once high, stays high with stable s_rid_o/s_rdata_o until s_rready_i; the head cannot change otherwise.
- count: +1 on AR handshake only, -1 on upstream R handshake only, unchanged if both or neither in the same cycle.
- Simultaneous events:
  - AR allocation into a slot being freed in the same cycle is impossible (allocation requires ~full).
  - AR alloc, downstream R write and upstream R pop may all occur in one cycle, each on different slots.
- Full: with 16 outstanding, AR is back-pressured (s_arready_o=0, m_arvalid_o=0) until one upstream R pop. AR acceptance resumes the following cycle.
- Empty: s_rvalid_o=0.
- Reset values:
  - s_rvalid_o=0, s_rid_o=0, s_rdata_o=0, m_rready_o=0
  - m_arid_o=0; m_arvalid_o follows s_arvalid_i; s_arready_o follows m_arready_i
  - pointers 0, count 0, all alloc/done 0

Test Plan:
- Sequential AR IDs 0..15 with m_arready_i=1 -> m_arid_o 0..15 in order. After 16th, s_arready_o=0 and m_arvalid_o=0 (full).
- Respond to the 16 slots in a random permutation with rdata=rid, s_rready_i=1 -> s_rid_o/s_rdata_o emitted 0,1,...,15 in order. No s_rvalid_o until slot 0 is returned.
- AR IDs 5,5,9; respond slot 2 (data 0xA2), slot 0 (0xA0), slot 1 (0xA1) -> upstream (rid,data) = (5,0xA0),(5,0xA1),(9,0xA2).
- s_rready_i=0 while head done -> s_rvalid_o held, data/ID stable. Assert s_rready_i -> pop next cycle. When full, one pop -> s_arready_o=1 next cycle, m_arid_o = 0 (wrap).
- m_arready_i=0 -> s_arready_o=0, no allocation. Spurious R to unallocated slot 7 -> accepted, no upstream output.
- rst_n low mid-stream with 6 outstanding -> s_rvalid_o=0 immediately, count 0. After release, the next AR gets m_arid_o=0.
